blake2_msg_pad: RTL

//  Upstream stage of the blake2 core. Takes the key and message as one byte

---
 rtl/blake2_pkg.sv | 28 ++
 rtl/blake2_blk_buf.sv | 36 +++
 rtl/blake2_msg_pad.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/blake2_pkg.sv
// ---------------------------------------------------------------------------
// blake2_pkg
// Shared constants and types for the blake2 message padding front end.
//   BLOCK_BYTES : bytes per compression block
//   BB          : width of the total byte count ll
//   KK_W        : width of key / digest length fields
//   IDX_W       : width of the core byte index data_idx
//   ADDR_W      : address width of the 64-entry block buffer
//   CNT_W       : width of the buffer fill counter (counts 0..64)
//   e_pad_fsm   : padding FSM states
// ---------------------------------------------------------------------------
package blake2_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int BB          = 128;
  localparam int KK_W        = 7;
  localparam int IDX_W       = 7;
  localparam int ADDR_W      = 6;
  localparam int CNT_W       = 7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL_KEY = 2'd1,
    S_FILL_MSG = 2'd2,
    S_DRAIN    = 2'd3
  } e_pad_fsm;

endpackage

// File: rtl/blake2_blk_buf.sv
// ---------------------------------------------------------------------------
// blake2_blk_buf
// 64x8 block buffer. One synchronous write port, one combinational read port
// that returns 8'h00 for any address at or beyond the current fill count, so
// the unwritten tail of a block reads back as zero padding.
//   clk        : clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_i    : read address
//   fill_cnt_i : number of valid bytes held in the buffer
//   rdata_o    : read data, zero-filled past fill_cnt_i
// ---------------------------------------------------------------------------
module blake2_blk_buf
  import blake2_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [CNT_W-1:0]  fill_cnt_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [BLOCK_BYTES];

  // NOTE: the storage array has no reset; stale contents are never visible
  // because reads past fill_cnt_i are forced to zero and fill_cnt resets to 0.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = ({1'b0, raddr_i} < fill_cnt_i) ? mem_q[raddr_i] : 8'h00;

endmodule

// File: rtl/blake2_msg_pad.sv
// ---------------------------------------------------------------------------
// blake2_msg_pad
// Front end of the blake2 core: collects key and message bytes from one byte
// stream into a 64-byte buffer, then drains each block to the core with the
// key block padded, the final block zero-padded, first/last flags, the byte
// index and the total byte count ll.
//   clk, nreset          : clock, asynchronous active-low reset
//   start_i              : begin a new hash (sampled in S_IDLE only)
//   kk_i, nn_i           : key / digest length, latched on start
//   msg_empty_i          : message has zero length, latched on start
//   s_valid_i/s_data_i   : input byte stream (key bytes first)
//   s_last_i             : final message byte (ignored during key bytes)
//   s_ready_o            : input byte accepted when s_valid_i & s_ready_o
//   core_ready_i         : core can take a byte this cycle
//   data_v_o/data_idx_o/data_o : byte to core and its index in the block
//   block_first_o/block_last_o : flags for the block being drained
//   ll_o                 : total byte count (64 extra when keyed)
//   kk_o, nn_o           : latched key / digest length
//   busy_o               : FSM not idle
// ---------------------------------------------------------------------------
module blake2_msg_pad
  import blake2_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             start_i,
  input  logic [KK_W-1:0]  kk_i,
  input  logic [KK_W-1:0]  nn_i,
  input  logic             msg_empty_i,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  input  logic             core_ready_i,
  output logic             data_v_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       data_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic [BB-1:0]    ll_o,
  output logic [KK_W-1:0]  kk_o,
  output logic [KK_W-1:0]  nn_o,
  output logic             busy_o
);

  e_pad_fsm         state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             msg_empty_q, msg_empty_d;
  logic [BB-1:0]    msg_cnt_q, msg_cnt_d;
  logic [BB-1:0]    ll_q, ll_d;
  logic [KK_W-1:0]  kk_q, kk_d;
  logic [KK_W-1:0]  nn_q, nn_d;
  logic             buf_we;

  // NOTE: every signal driven here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    first_d     = first_q;
    last_d      = last_q;
    msg_empty_d = msg_empty_q;
    msg_cnt_d   = msg_cnt_q;
    kk_d        = kk_q;
    nn_d        = nn_q;
    buf_we      = 1'b0;
    s_ready_o   = 1'b0;
    data_v_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          kk_d        = kk_i;
          nn_d        = nn_i;
          msg_empty_d = msg_empty_i;
          first_d     = 1'b1;
          last_d      = 1'b0;
          msg_cnt_d   = '0;
          fill_d      = '0;
          idx_d       = '0;
          if (kk_i != '0)       state_d = S_FILL_KEY;
          else if (!msg_empty_i) state_d = S_FILL_MSG;
          else begin
            // Unkeyed empty hash: a single all-zero last block.
            state_d = S_DRAIN;
            last_d  = 1'b1;
          end
        end
      end

      S_FILL_KEY: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          buf_we = 1'b1;
          fill_d = fill_q + CNT_W'(1);
          // The key block is the last block only when no message follows.
          if ((fill_q + CNT_W'(1)) == CNT_W'(kk_q)) begin
            state_d = S_DRAIN;
            last_d  = msg_empty_q;
          end
        end
      end

      S_FILL_MSG: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          buf_we    = 1'b1;
          fill_d    = fill_q + CNT_W'(1);
          msg_cnt_d = msg_cnt_q + BB'(1);
          if (fill_q == CNT_W'(BLOCK_BYTES - 1) || s_last_i) begin
            state_d = S_DRAIN;
            last_d  = s_last_i;
          end
        end
      end

      S_DRAIN: begin
        data_v_o = core_ready_i;
        if (core_ready_i) begin
          if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
            idx_d   = '0;
            fill_d  = '0;
            first_d = 1'b0;
            state_d = last_q ? S_IDLE : S_FILL_MSG;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Keyed hashes count the padded key block as 64 bytes of input.
    ll_d = msg_cnt_d + ((kk_d != '0) ? BB'(BLOCK_BYTES) : BB'(0));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      fill_q      <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      msg_empty_q <= 1'b0;
      msg_cnt_q   <= '0;
      ll_q        <= '0;
      kk_q        <= '0;
      nn_q        <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      last_q      <= last_d;
      msg_empty_q <= msg_empty_d;
      msg_cnt_q   <= msg_cnt_d;
      ll_q        <= ll_d;
      kk_q        <= kk_d;
      nn_q        <= nn_d;
    end
  end

  blake2_blk_buf u_buf (
    .clk        (clk),
    .we_i       (buf_we),
    .waddr_i    (fill_q[ADDR_W-1:0]),
    .wdata_i    (s_data_i),
    .raddr_i    (idx_q[ADDR_W-1:0]),
    .fill_cnt_i (fill_q),
    .rdata_o    (data_o)
  );

  assign data_idx_o    = idx_q;
  assign block_first_o = first_q;
  assign block_last_o  = last_q;
  assign ll_o          = ll_q;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
